// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier sequencer.
// Holds the FSM state encoding, default operand width and multiplier sign-extension.
package spm_pkg;

    localparam int SPM_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } spm_state_e;

    // Sign-extends the low w bits of val to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sign_ext(input logic [63:0] val, input int w);
        logic signed [63:0] tmp;
        tmp = $signed(val << (64 - w));
        return tmp >>> (64 - w);
    endfunction

endpackage

// File: rtl/spm_prod_deser.sv
// PW-bit LSB-first deserialiser for the SPM product stream.
// Latency: one bit per enabled cycle; word complete after PW enabled cycles.
// Backpressure: none; holds its contents while en is low.
module spm_prod_deser #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [PW-1:0] data
);

    // New bits enter at the MSB so the first bit ends at bit 0 after PW shifts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data <= '0;
        end else if (clr) begin
            data <= '0;
        end else if (en) begin
            data <= {bit_in, data[PW-1:1]};
        end
    end

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the signed WIDTHxWIDTH serial-parallel multiplier.
// Latency: accept cycle to out_valid is 2*WIDTH+2 cycles; issue interval 2*WIDTH+3.
// Backpressure: holds the product in DONE until out_ready; in_ready only in IDLE.
module spm_seq_ctrl
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [WIDTH-1:0]     mcand_q,
    output logic                 spm_clear,
    output logic                 spm_en,
    input  logic                 spm_prod_bit,
    output logic                 sreg_load,
    output logic                 sreg_shift,
    output logic [2*WIDTH-1:0]   sreg_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(PW);

    spm_state_e       state;
    spm_state_e       state_nxt;
    logic             accept;
    logic [CNT_W-1:0] cnt;

    assign in_ready = (state == IDLE);
    assign busy     = !in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = LOAD;
                    accept    = 1'b1;
                end
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (cnt == CNT_W'(PW - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they name.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            mcand_q    <= '0;
            sreg_in    <= '0;
            out_valid  <= 1'b0;
            spm_en     <= 1'b0;
            spm_clear  <= 1'b0;
            sreg_load  <= 1'b0;
            sreg_shift <= 1'b0;
        end else begin
            if (accept) begin
                mcand_q <= multiplicand;
                sreg_in <= PW'(sign_ext(64'(multiplier), WIDTH));
            end
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
            sreg_load  <= (state_nxt == LOAD);
            spm_clear  <= (state_nxt == LOAD);
            spm_en     <= (state_nxt == RUN);
            sreg_shift <= (state_nxt == RUN);
            out_valid  <= (state_nxt == DONE);
        end
    end

    spm_prod_deser #(
        .PW (PW)
    ) u_deser (
        .clk    (clk),
        .rst    (rst),
        .clr    (spm_clear),
        .en     (spm_en),
        .bit_in (spm_prod_bit),
        .data   (product)
    );

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl with a behavioural right_register and signed SPM around it.
module tb_spm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [7:0]  mcand_q;
    logic        spm_clear;
    logic        spm_en;
    logic        spm_prod_bit;
    logic        sreg_load;
    logic        sreg_shift;
    logic [15:0] sreg_in;
    logic [15:0] product;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    spm_seq_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mcand_q      (mcand_q),
        .spm_clear    (spm_clear),
        .spm_en       (spm_en),
        .spm_prod_bit (spm_prod_bit),
        .sreg_load    (sreg_load),
        .sreg_shift   (sreg_shift),
        .sreg_in      (sreg_in),
        .product      (product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    // right_register: parallel load, LSB-first shift
    logic [15:0] rr;
    always @(posedge clk) begin
        if (!rst)            rr <= '0;
        else if (sreg_load)  rr <= sreg_in;
        else if (sreg_shift) rr <= {rr[15], rr[15:1]};
    end

    // Behavioural signed SPM: add the partial product, emit the LSB, arithmetic shift
    logic signed [31:0] acc;
    logic signed [31:0] mc_ext;
    logic signed [31:0] psum;
    assign mc_ext       = {{24{mcand_q[7]}}, mcand_q};
    assign psum         = acc + (rr[0] ? mc_ext : 32'sd0);
    assign spm_prod_bit = psum[0];
    always @(posedge clk) begin
        if (!rst)           acc <= '0;
        else if (spm_clear) acc <= '0;
        else if (spm_en)    acc <= psum >>> 1;
    end

    // Presents an operand pair at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        in_valid     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL issue_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(negedge clk);
        in_valid     = 1'b0;
        multiplicand = 8'h5A;
        multiplier   = 8'hA5;
    endtask

    // Called one cycle after accept; lat counts cycles from the accept cycle.
    task automatic wait_result(output int lat, output int nload, output int nshift);
        int cyc = 1;
        nload  = 0;
        nshift = 0;
        while (!out_valid && cyc < 60) begin
            nload  += int'(sreg_load);
            nshift += int'(sreg_shift);
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        if (!out_valid) begin
            n_chk++;
            $display("FAIL result_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, cyc);
        end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({out_valid, spm_en, spm_clear, sreg_load, sreg_shift, busy} !== 6'b0)
            $display("FAIL reset_strobes: got %b required 000000",
                     {out_valid, spm_en, spm_clear, sreg_load, sreg_shift, busy});
        else n_pass++;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else n_pass++;
        n_chk++;
        if ({product, sreg_in, mcand_q} !== 40'h0)
            $display("FAIL reset_data: got %h/%h/%h required 0", product, sreg_in, mcand_q);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat, nl, ns;
        out_ready = 1'b1;
        issue(8'd3, 8'd5);
        wait_result(lat, nl, ns);
        n_chk++;
        if (lat !== 18) $display("FAIL basic_latency: got %0d required 18", lat);
        else n_pass++;
        n_chk++;
        if (product !== 16'h000F) $display("FAIL basic_product: got %h required 000f", product);
        else n_pass++;
        n_chk++;
        if (nl !== 1) $display("FAIL basic_load_cycles: got %0d required 1", nl);
        else n_pass++;
        n_chk++;
        if (ns !== 16) $display("FAIL basic_shift_cycles: got %0d required 16", ns);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL basic_return_idle: got in_ready/out_valid=%b required 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_corners();
        logic [7:0]  ta [4] = '{8'h80, 8'hFF, 8'h80, 8'h00};
        logic [7:0]  tb [4] = '{8'h80, 8'h7F, 8'h7F, 8'hB3};
        logic [15:0] te [4] = '{16'h4000, 16'hFF81, 16'hC080, 16'h0000};
        int lat, nl, ns;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i]);
            wait_result(lat, nl, ns);
            n_chk++;
            if (product !== te[i])
                $display("FAIL corner_%0d: %h*%h got %h required %h", i, ta[i], tb[i], product, te[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat, nl, ns;
        out_ready = 1'b0;
        issue(8'd12, 8'hFD);
        wait_result(lat, nl, ns);
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if ({out_valid, in_ready, product} !== {2'b10, 16'hFFDC})
                $display("FAIL bp_hold_%0d: got valid=%b ready=%b prod=%h required 1 0 ffdc",
                         i, out_valid, in_ready, product);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL bp_release: got in_ready/out_valid=%b required 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_ignore();
        int lat, nl, ns;
        int seen = 0;
        out_ready = 1'b1;
        issue(8'd9, 8'hF5);
        repeat (4) @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = 8'd100;
        multiplier   = 8'd100;
        n_chk++;
        if (in_ready !== 1'b0) $display("FAIL ignore_in_ready: got %b required 0", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat, nl, ns);
        n_chk++;
        if (product !== 16'hFF9D) $display("FAIL ignore_product: got %h required ff9d", product);
        else n_pass++;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            seen += int'(out_valid) + int'(busy);
            @(negedge clk);
        end
        n_chk++;
        if (seen !== 0) $display("FAIL ignore_no_second: got %0d busy/valid cycles required 0", seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, nl, ns;
        out_ready = 1'b1;
        issue(8'd50, 8'd50);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({out_valid, spm_en, spm_clear, sreg_load, sreg_shift, in_ready} !== 6'b000001)
            $display("FAIL midrst_strobes: got %b required 000001",
                     {out_valid, spm_en, spm_clear, sreg_load, sreg_shift, in_ready});
        else n_pass++;
        n_chk++;
        if ({product, sreg_in, mcand_q} !== 40'h0)
            $display("FAIL midrst_data: got %h/%h/%h required 0", product, sreg_in, mcand_q);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        issue(8'd7, 8'hF7);
        wait_result(lat, nl, ns);
        n_chk++;
        if (product !== 16'hFFC1) $display("FAIL midrst_product: got %h required ffc1", product);
        else n_pass++;
        n_chk++;
        if (lat !== 18) $display("FAIL midrst_latency: got %0d required 18", lat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic signed [7:0]  ra, rb;
        logic signed [15:0] e;
        logic [15:0]        expq [$];
        int cyc = 0, prev = -1, issued = 0, done = 0;
        logic accepted;
        out_ready    = 1'b1;
        ra           = 8'($urandom);
        rb           = 8'($urandom);
        multiplicand = ra;
        multiplier   = rb;
        in_valid     = 1'b1;
        while (done < 200 && cyc < 6000) begin
            accepted = 1'b0;
            if (in_valid && in_ready) begin
                e = ra * rb;
                expq.push_back(e);
                if (prev >= 0) begin
                    n_chk++;
                    if (cyc - prev !== 19)
                        $display("FAIL b2b_interval_%0d: got %0d required 19", issued, cyc - prev);
                    else n_pass++;
                end
                prev = cyc;
                issued++;
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_chk++;
                if (expq.size() == 0)
                    $display("FAIL b2b_spurious: got result %h required none", product);
                else if (product !== expq[0])
                    $display("FAIL b2b_product_%0d: got %h required %h", done, product, expq[0]);
                else n_pass++;
                if (expq.size() != 0) void'(expq.pop_front());
                done++;
            end
            @(negedge clk);
            cyc++;
            if (accepted) begin
                if (issued < 200) begin
                    ra           = 8'($urandom);
                    rb           = 8'($urandom);
                    multiplicand = ra;
                    multiplier   = rb;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        if (done < 200) begin
            n_chk++;
            $display("FAIL b2b_timeout: got %0d results required 200", done);
        end
    endtask

    initial begin
        rst          = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_basic();
        test_corners();
        test_backpressure();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
